// File: rtl/pump_pkg.sv
// Shared types and constants for the pump drive sequencer.
// Holds the FSM state encoding, PWM limits, ownership codes and the saturating step helper.
package pump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN_A,
        ST_RUN_B,
        ST_RAMP_DOWN,
        ST_DEAD
    } pump_state_t;

    localparam logic [7:0] PWM_MAX = 8'd230;
    localparam logic [7:0] PWM_MIN = 8'd77;

    localparam logic [1:0] PUMP_NONE = 2'b00;
    localparam logic [1:0] PUMP_A    = 2'b01;
    localparam logic [1:0] PUMP_B    = 2'b10;

    // Move cur toward tgt by at most step; 9-bit intermediates keep the result from wrapping.
    function automatic logic [7:0] sat_step(input logic [7:0] cur,
                                            input logic [7:0] tgt,
                                            input logic [7:0] step);
        logic [8:0] diff;
        logic [8:0] moved;
        diff     = 9'd0;
        moved    = 9'd0;
        sat_step = cur;
        if (tgt > cur) begin
            diff     = {1'b0, tgt} - {1'b0, cur};
            moved    = {1'b0, cur} + {1'b0, step};
            sat_step = (diff <= {1'b0, step}) ? tgt : 8'(moved);
        end else if (tgt < cur) begin
            diff     = {1'b0, cur} - {1'b0, tgt};
            moved    = {1'b0, cur} - {1'b0, step};
            sat_step = (diff <= {1'b0, step}) ? tgt : 8'(moved);
        end
    endfunction

endpackage

// File: rtl/duty_ramp.sv
// Saturating duty stepper shared by whichever pump currently owns the drive.
// On tick the duty moves one STEP toward target without overshoot; otherwise it holds.
module duty_ramp
    import pump_pkg::*;
#(
    parameter logic [7:0] STEP = 8'd1
) (
    input  logic [7:0] current,
    input  logic [7:0] target,
    input  logic       tick,
    output logic [7:0] next
);

    always_comb begin
        next = current;
        if (tick) begin
            next = sat_step(current, target, STEP);
        end
    end

endmodule

// File: rtl/pump_drive_sequencer.sv
// Two-pump drive sequencer with ramping, dead-time handover, estop and interlock detection.
// Define PUMP_RAMP_EN to ramp duties per tick; without it duties jump straight to the request.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_IDLE      | both duties 0, waiting for a request (A has priority)
// ST_RUN_A     | pump A owns the drive, duty A tracks req_duty_a
// ST_RUN_B     | pump B owns the drive, duty B tracks req_duty_b
// ST_RAMP_DOWN | owned duty falls to 0 before the handover
// ST_DEAD      | both duties 0 for DEAD_TIME_CYCLES, requests ignored; held by estop
module pump_drive_sequencer
    import pump_pkg::*;
#(
    parameter int         RAMP_DIV         = 50_000,
    parameter logic [7:0] RAMP_STEP        = 8'd1,
    parameter int         DEAD_TIME_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req_duty_a,
    input  logic [7:0] req_duty_b,
    input  logic       estop,
    output logic [7:0] pwm_duty_a,
    output logic [7:0] pwm_duty_b,
    output logic [1:0] active_pump,
    output logic       interlock_err
);

`ifdef PUMP_RAMP_EN
    localparam bit         RAMP_EN  = 1'b1;
    localparam logic [7:0] EFF_STEP = RAMP_STEP;
`else
    // A full-scale step every cycle makes the shared stepper a plain copy of the target.
    localparam bit         RAMP_EN  = 1'b0;
    localparam logic [7:0] EFF_STEP = 8'hFF;
`endif

    localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DEAD_TIME_CYCLES > 1) ? $clog2(DEAD_TIME_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DEAD_LOAD =
        (DEAD_TIME_CYCLES > 0) ? DW'(DEAD_TIME_CYCLES - 1) : '0;

    pump_state_t   state;
    logic          owner_a;
    logic [TW-1:0] tick_cnt;
    logic [DW-1:0] dead_cnt;
    logic          ramp_tick;
    logic          step_en;
    logic [7:0]    cur_duty;
    logic [7:0]    tgt_duty;
    logic [7:0]    next_duty;

    assign ramp_tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (ramp_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign step_en  = ramp_tick | ~RAMP_EN;
    assign cur_duty = owner_a ? pwm_duty_a : pwm_duty_b;
    assign tgt_duty = (state == ST_RAMP_DOWN) ? 8'd0 : (owner_a ? req_duty_a : req_duty_b);

    duty_ramp #(
        .STEP(EFF_STEP)
    ) u_duty_ramp (
        .current(cur_duty),
        .target (tgt_duty),
        .tick   (step_en),
        .next   (next_duty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            owner_a       <= 1'b0;
            dead_cnt      <= '0;
            pwm_duty_a    <= 8'd0;
            pwm_duty_b    <= 8'd0;
            active_pump   <= PUMP_NONE;
            interlock_err <= 1'b0;
        end else begin
            interlock_err <= (req_duty_a != 8'd0) && (req_duty_b != 8'd0) && (state != ST_DEAD);
            if (estop) begin
                // Reloading here restarts the dead time from the cycle estop releases.
                state       <= ST_DEAD;
                dead_cnt    <= DEAD_LOAD;
                pwm_duty_a  <= 8'd0;
                pwm_duty_b  <= 8'd0;
                active_pump <= PUMP_NONE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        pwm_duty_a  <= 8'd0;
                        pwm_duty_b  <= 8'd0;
                        active_pump <= PUMP_NONE;
                        if (req_duty_a != 8'd0) begin
                            state       <= ST_RUN_A;
                            owner_a     <= 1'b1;
                            active_pump <= PUMP_A;
                        end else if (req_duty_b != 8'd0) begin
                            state       <= ST_RUN_B;
                            owner_a     <= 1'b0;
                            active_pump <= PUMP_B;
                        end
                    end
                    ST_RUN_A: begin
                        pwm_duty_b <= 8'd0;
                        if ((req_duty_a == 8'd0) || (req_duty_b != 8'd0)) begin
                            state <= ST_RAMP_DOWN;
                        end else begin
                            pwm_duty_a <= next_duty;
                        end
                    end
                    ST_RUN_B: begin
                        pwm_duty_a <= 8'd0;
                        if ((req_duty_b == 8'd0) || (req_duty_a != 8'd0)) begin
                            state <= ST_RAMP_DOWN;
                        end else begin
                            pwm_duty_b <= next_duty;
                        end
                    end
                    ST_RAMP_DOWN: begin
                        if ((cur_duty == 8'd0) || !RAMP_EN) begin
                            state       <= ST_DEAD;
                            dead_cnt    <= DEAD_LOAD;
                            pwm_duty_a  <= 8'd0;
                            pwm_duty_b  <= 8'd0;
                            active_pump <= PUMP_NONE;
                        end else if (owner_a) begin
                            pwm_duty_a <= next_duty;
                        end else begin
                            pwm_duty_b <= next_duty;
                        end
                    end
                    ST_DEAD: begin
                        pwm_duty_a  <= 8'd0;
                        pwm_duty_b  <= 8'd0;
                        active_pump <= PUMP_NONE;
                        if (dead_cnt == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            dead_cnt <= dead_cnt - DW'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pump_drive_sequencer.sv
// Directed self-checking bench for pump_drive_sequencer (RAMP_DIV=4, RAMP_STEP=8, dead time 10).
// Expectations follow PUMP_RAMP_EN so the same bench serves both builds.
module tb_pump_drive_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] req_duty_a;
    logic [7:0] req_duty_b;
    logic       estop;
    logic [7:0] pwm_duty_a;
    logic [7:0] pwm_duty_b;
    logic [1:0] active_pump;
    logic       interlock_err;

    int errors = 0;
    int checks = 0;

    pump_drive_sequencer #(
        .RAMP_DIV        (4),
        .RAMP_STEP       (8'd8),
        .DEAD_TIME_CYCLES(10)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_duty_a   (req_duty_a),
        .req_duty_b   (req_duty_b),
        .estop        (estop),
        .pwm_duty_a   (pwm_duty_a),
        .pwm_duty_b   (pwm_duty_b),
        .active_pump  (active_pump),
        .interlock_err(interlock_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req_duty_a = 8'd0;
        req_duty_b = 8'd0;
        estop      = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pwm_duty_a !== 8'd0) begin errors++; $display("FAIL reset_duty_a: got %0d expected 0", pwm_duty_a); end
        checks++; if (pwm_duty_b !== 8'd0) begin errors++; $display("FAIL reset_duty_b: got %0d expected 0", pwm_duty_b); end
        checks++; if (active_pump !== 2'b00) begin errors++; $display("FAIL reset_active: got %b expected 00", active_pump); end
        checks++; if (interlock_err !== 1'b0) begin errors++; $display("FAIL reset_interlock: got %b expected 0", interlock_err); end
        step();
        step();
        checks++; if (active_pump !== 2'b00) begin errors++; $display("FAIL idle_no_request: got %b expected 00", active_pump); end
    endtask

    task automatic test_ramp_up_a();
        int         steps;
        int         cyc_i;
        int         last_change;
        int         bad_step;
        int         bad_gap;
        int         bad_b;
        logic [7:0] prev;
        logic [7:0] expv;
        do_reset();
        req_duty_a = 8'd230;
        step();
        checks++; if (active_pump !== 2'b01) begin errors++; $display("FAIL run_a_active: got %b expected 01", active_pump); end
        checks++; if (pwm_duty_a !== 8'd0) begin errors++; $display("FAIL run_a_entry_duty: got %0d expected 0", pwm_duty_a); end
`ifdef PUMP_RAMP_EN
        steps = 0; cyc_i = 0; last_change = -1; bad_step = 0; bad_gap = 0; bad_b = 0; prev = 8'd0;
        for (int i = 0; i < 200 && pwm_duty_a != 8'd230; i++) begin
            step();
            cyc_i++;
            if (pwm_duty_b != 8'd0) bad_b++;
            if (pwm_duty_a != prev) begin
                expv = (8'd230 - prev > 8'd8) ? prev + 8'd8 : 8'd230;
                if (pwm_duty_a !== expv) bad_step++;
                if (last_change >= 0 && (cyc_i - last_change) != 4) bad_gap++;
                last_change = cyc_i;
                steps++;
                prev = pwm_duty_a;
            end
        end
        checks++; if (pwm_duty_a !== 8'd230) begin errors++; $display("FAIL ramp_a_final: got %0d expected 230", pwm_duty_a); end
        checks++; if (steps != 29) begin errors++; $display("FAIL ramp_a_ticks: got %0d expected 29", steps); end
        checks++; if (bad_step != 0) begin errors++; $display("FAIL ramp_a_step_size: got %0d bad steps expected 0", bad_step); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL ramp_a_tick_period: got %0d bad gaps expected 0", bad_gap); end
        checks++; if (bad_b != 0) begin errors++; $display("FAIL ramp_a_b_zero: got %0d nonzero cycles expected 0", bad_b); end
        for (int i = 0; i < 8; i++) step();
        checks++; if (pwm_duty_a !== 8'd230) begin errors++; $display("FAIL ramp_a_hold: got %0d expected 230", pwm_duty_a); end
`else
        step();
        checks++; if (pwm_duty_a !== 8'd230) begin errors++; $display("FAIL direct_a: got %0d expected 230", pwm_duty_a); end
        checks++; if (pwm_duty_b !== 8'd0) begin errors++; $display("FAIL direct_a_b_zero: got %0d expected 0", pwm_duty_b); end
        req_duty_a = 8'd100;
        step();
        checks++; if (pwm_duty_a !== 8'd100) begin errors++; $display("FAIL direct_a_track_down: got %0d expected 100", pwm_duty_a); end
        req_duty_a = 8'd230;
        step();
        checks++; if (pwm_duty_a !== 8'd230) begin errors++; $display("FAIL direct_a_track_up: got %0d expected 230", pwm_duty_a); end
`endif
    endtask

    task automatic test_handover();
        int         n;
        int         bad_dead;
        int         bad_other;
        int         bad_dn;
        logic [7:0] prev;
        logic [7:0] expv;
        bad_dead = 0; bad_other = 0; bad_dn = 0;
        req_duty_b = 8'd77;
        step();
        checks++; if (interlock_err !== 1'b1) begin errors++; $display("FAIL handover_interlock: got %b expected 1", interlock_err); end
        checks++; if (active_pump !== 2'b01) begin errors++; $display("FAIL ramp_down_owner_a: got %b expected 01", active_pump); end
        req_duty_a = 8'd0;
        step();
        checks++; if (interlock_err !== 1'b0) begin errors++; $display("FAIL interlock_one_cycle: got %b expected 0", interlock_err); end
`ifdef PUMP_RAMP_EN
        prev = pwm_duty_a;
        for (int i = 0; i < 200 && pwm_duty_a != 8'd0; i++) begin
            step();
            if (pwm_duty_b != 8'd0) bad_other++;
            if (pwm_duty_a != prev) begin
                expv = (prev > 8'd8) ? prev - 8'd8 : 8'd0;
                if (pwm_duty_a !== expv) bad_dn++;
                prev = pwm_duty_a;
            end
        end
        checks++; if (pwm_duty_a !== 8'd0) begin errors++; $display("FAIL ramp_down_a_final: got %0d expected 0", pwm_duty_a); end
        checks++; if (bad_dn != 0) begin errors++; $display("FAIL ramp_down_a_step: got %0d bad steps expected 0", bad_dn); end
        checks++; if (active_pump !== 2'b01) begin errors++; $display("FAIL ramp_down_zero_cycle: got %b expected 01", active_pump); end
        step();
`else
        checks++; if (pwm_duty_a !== 8'd0) begin errors++; $display("FAIL direct_ramp_down_a: got %0d expected 0", pwm_duty_a); end
`endif
        checks++; if (active_pump !== 2'b00) begin errors++; $display("FAIL dead_entry_active: got %b expected 00", active_pump); end
        n = 0;
        while (active_pump != 2'b10 && n < 40) begin
            step();
            n++;
            if (active_pump != 2'b10 && (pwm_duty_a != 8'd0 || pwm_duty_b != 8'd0)) bad_dead++;
        end
        checks++; if (n != 11) begin errors++; $display("FAIL dead_time_len: got %0d edges expected 11", n); end
        checks++; if (bad_dead != 0) begin errors++; $display("FAIL dead_duties_zero: got %0d nonzero cycles expected 0", bad_dead); end
        for (int i = 0; i < 100 && pwm_duty_b != 8'd77; i++) begin
            step();
            if (pwm_duty_a != 8'd0 || pwm_duty_b > 8'd77) bad_other++;
        end
        checks++; if (pwm_duty_b !== 8'd77) begin errors++; $display("FAIL ramp_b_final: got %0d expected 77", pwm_duty_b); end
        checks++; if (bad_other != 0) begin errors++; $display("FAIL handover_exclusive: got %0d bad cycles expected 0", bad_other); end
    endtask

    task automatic test_both_idle();
        int bad_b;
        bad_b = 0;
        do_reset();
        req_duty_a = 8'd100;
        req_duty_b = 8'd100;
        step();
        checks++; if (interlock_err !== 1'b1) begin errors++; $display("FAIL idle_both_interlock: got %b expected 1", interlock_err); end
        checks++; if (active_pump !== 2'b01) begin errors++; $display("FAIL idle_both_a_wins: got %b expected 01", active_pump); end
        req_duty_b = 8'd0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (pwm_duty_b != 8'd0) bad_b++;
        end
        checks++; if (bad_b != 0) begin errors++; $display("FAIL idle_both_b_zero: got %0d nonzero cycles expected 0", bad_b); end
        checks++; if (pwm_duty_a !== 8'd100) begin errors++; $display("FAIL idle_both_a_duty: got %0d expected 100", pwm_duty_a); end
    endtask

    task automatic test_estop();
        int n;
        int bad_hold;
        bad_hold = 0;
        do_reset();
        req_duty_a = 8'd120;
        for (int i = 0; i < 100 && pwm_duty_a != 8'd120; i++) step();
        checks++; if (pwm_duty_a !== 8'd120) begin errors++; $display("FAIL estop_setup: got %0d expected 120", pwm_duty_a); end
        estop = 1'b1;
        step();
        checks++; if (pwm_duty_a !== 8'd0) begin errors++; $display("FAIL estop_duty_a: got %0d expected 0", pwm_duty_a); end
        checks++; if (active_pump !== 2'b00) begin errors++; $display("FAIL estop_active: got %b expected 00", active_pump); end
        req_duty_b = 8'd50;
        for (int i = 0; i < 5; i++) begin
            step();
            if (pwm_duty_a != 8'd0 || pwm_duty_b != 8'd0 || active_pump != 2'b00 || interlock_err != 1'b0) bad_hold++;
        end
        checks++; if (bad_hold != 0) begin errors++; $display("FAIL estop_hold_dead: got %0d bad cycles expected 0", bad_hold); end
        req_duty_b = 8'd0;
        estop      = 1'b0;
        n = 0;
        while (active_pump != 2'b01 && n < 40) begin
            step();
            n++;
        end
        checks++; if (n != 11) begin errors++; $display("FAIL estop_restart_count: got %0d edges expected 11", n); end
    endtask

    task automatic test_reset_mid_ramp();
        req_duty_a = 8'd230;
        for (int i = 0; i < 100 && pwm_duty_a < 8'd40; i++) step();
        checks++; if (pwm_duty_a < 8'd40) begin errors++; $display("FAIL mid_ramp_setup: got %0d expected >=40", pwm_duty_a); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (pwm_duty_a !== 8'd0) begin errors++; $display("FAIL async_reset_duty_a: got %0d expected 0", pwm_duty_a); end
        checks++; if (active_pump !== 2'b00) begin errors++; $display("FAIL async_reset_active: got %b expected 00", active_pump); end
        step();
        req_duty_a = 8'd0;
        reset_n    = 1'b1;
    endtask

    task automatic test_reset_mid_dead();
        req_duty_a = 8'd50;
        step();
        estop = 1'b1;
        step();
        estop      = 1'b0;
        req_duty_a = 8'd0;
        step();
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (active_pump !== 2'b00 || pwm_duty_a !== 8'd0 || pwm_duty_b !== 8'd0 || interlock_err !== 1'b0) begin
            errors++; $display("FAIL reset_mid_dead_outputs: got a=%0d b=%0d act=%b il=%b expected all 0", pwm_duty_a, pwm_duty_b, active_pump, interlock_err);
        end
        step();
        reset_n    = 1'b1;
        req_duty_b = 8'd77;
        step();
        checks++; if (active_pump !== 2'b10) begin errors++; $display("FAIL reset_skips_dead: got %b expected 10", active_pump); end
    endtask

    task automatic test_ramp_down_b();
`ifdef PUMP_RAMP_EN
        int         bad_dn;
        logic [7:0] prev;
        logic [7:0] expv;
        bad_dn = 0;
        for (int i = 0; i < 100 && pwm_duty_b != 8'd77; i++) step();
        req_duty_b = 8'd0;
        step();
        prev = pwm_duty_b;
        for (int i = 0; i < 100 && pwm_duty_b != 8'd0; i++) begin
            step();
            if (pwm_duty_b != prev) begin
                expv = (prev > 8'd8) ? prev - 8'd8 : 8'd0;
                if (pwm_duty_b !== expv) bad_dn++;
                prev = pwm_duty_b;
            end
        end
        checks++; if (pwm_duty_b !== 8'd0 || bad_dn != 0) begin errors++; $display("FAIL ramp_down_b: got duty %0d bad steps %0d expected 0 and 0", pwm_duty_b, bad_dn); end
        checks++; if (active_pump !== 2'b10) begin errors++; $display("FAIL ramp_down_b_owner: got %b expected 10", active_pump); end
        step();
        checks++; if (active_pump !== 2'b00) begin errors++; $display("FAIL ramp_down_b_dead: got %b expected 00", active_pump); end
`else
        do_reset();
        req_duty_b = 8'd230;
        step();
        checks++; if (active_pump !== 2'b10) begin errors++; $display("FAIL direct_b_active: got %b expected 10", active_pump); end
        step();
        checks++; if (pwm_duty_b !== 8'd230) begin errors++; $display("FAIL direct_b_duty: got %0d expected 230", pwm_duty_b); end
        req_duty_b = 8'd0;
        step();
        checks++; if (pwm_duty_b !== 8'd230 || active_pump !== 2'b10) begin errors++; $display("FAIL direct_b_ramp_down_entry: got %0d/%b expected 230/10", pwm_duty_b, active_pump); end
        step();
        checks++; if (pwm_duty_b !== 8'd0 || active_pump !== 2'b00) begin errors++; $display("FAIL direct_b_ramp_down_one_cycle: got %0d/%b expected 0/00", pwm_duty_b, active_pump); end
`endif
    endtask

    initial begin
        reset_n    = 1'b0;
        req_duty_a = 8'd0;
        req_duty_b = 8'd0;
        estop      = 1'b0;
        test_reset();
        test_ramp_up_a();
        test_handover();
        test_both_idle();
        test_estop();
        test_reset_mid_ramp();
        test_reset_mid_dead();
        test_ramp_down_b();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pump_drive_sequencer.md
PUMP_DRIVE_SEQUENCER -- requirements
Module: pump_drive_sequencer

Interface
REQ-001 Parameter RAMP_DIV, default 50_000: clock cycles per ramp tick (1 ms @ 50 MHz); legal range >= 1.
REQ-002 Parameter RAMP_STEP, default 8'd1: duty change applied per ramp tick; legal range >= 1.
REQ-003 Parameter DEAD_TIME_CYCLES, default 25_000_000: idle gap enforced between pump handovers (0.5 s @ 50 MHz).
REQ-004 clk  input  1  single system clock; all logic is rising-edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req_duty_a  input  8  requested duty for pump A (fill); 0 = off.
REQ-007 req_duty_b  input  8  requested duty for pump B (drain); 0 = off.
REQ-008 estop  input  1  emergency stop, level-sensitive, already synchronised.
REQ-009 pwm_duty_a  output  8  registered duty to the PWM generator, pump A.
REQ-010 pwm_duty_b  output  8  registered duty to the PWM generator, pump B.
REQ-011 active_pump  output  2  2'b01 = A owns the drive, 2'b10 = B owns it, 2'b00 = none.
REQ-012 interlock_err  output  1  one-cycle pulse when both requests are non-zero in the same cycle.

Function
REQ-013 States SHALL be IDLE, RUN_A, RUN_B, RAMP_DOWN and DEAD; pwm_duty_a and pwm_duty_b SHALL never both be non-zero in any cycle.
REQ-014 A free-running tick counter SHALL count 0..RAMP_DIV-1, wrap to 0, and assert ramp_tick for one cycle on each wrap.
REQ-015 IDLE: both duties SHALL be 0; req_duty_a != 0 SHALL go to RUN_A, otherwise req_duty_b != 0 SHALL go to RUN_B; A SHALL win when both are non-zero.
REQ-016 RUN_A/RUN_B: on each ramp_tick the owned duty SHALL move toward its request by RAMP_STEP, saturating so it never overshoots (|target-cur| <= RAMP_STEP sets cur = target); the other duty SHALL stay 0.
REQ-017 RUN_A SHALL go to RAMP_DOWN when req_duty_a == 0 or req_duty_b != 0; RUN_B SHALL do the same with A and B swapped.
REQ-018 RAMP_DOWN: the owned duty SHALL decrease by RAMP_STEP per ramp_tick, saturating at 0; the state SHALL go to DEAD in the cycle after the duty reaches 0.
REQ-019 DEAD: both duties SHALL be 0 and active_pump SHALL be 2'b00; a counter SHALL count DEAD_TIME_CYCLES cycles and then go to IDLE, ignoring requests until then.
REQ-020 estop high in any state SHALL force both duties to 0 on the next edge and enter DEAD; DEAD SHALL hold while estop is high, and the count SHALL restart after estop deasserts.
REQ-021 interlock_err SHALL pulse in every cycle where both requests are non-zero and the state is not DEAD.
REQ-022 active_pump SHALL reflect ownership: RUN_A and RAMP_DOWN-from-A give 01, RUN_B and RAMP_DOWN-from-B give 10.
REQ-023 Duty arithmetic SHALL be unsigned 8-bit with 9-bit intermediates; no wrap-around is permitted.

Reset
REQ-024 reset_n low SHALL asynchronously set the state to IDLE, both duties to 0, active_pump to 00, interlock_err to 0 and all counters to 0, including when asserted mid-ramp or mid-dead-time.

Configuration
REQ-025 With PUMP_RAMP_EN defined, ramping SHALL behave as in REQ-016/018.
REQ-026 Without PUMP_RAMP_EN, the owned duty SHALL equal its request in the cycle after RUN is entered and track it every cycle; RAMP_DOWN SHALL zero the duty at once and last exactly one cycle.

Structure
REQ-027 Package pump_pkg SHALL hold the state enum, PWM_MAX = 8'd230, PWM_MIN = 8'd77, and the active_pump encodings.
REQ-028 Sub-module duty_ramp (current, target, tick in; next duty out; saturating step) SHALL be instantiated once and shared by the active pump.

Verification (RAMP_DIV=4, RAMP_STEP=8, DEAD_TIME_CYCLES=10, PUMP_RAMP_EN defined unless stated)
REQ-029 req_duty_a=230 from IDLE -> pwm_duty_a rises 8 per 4 cycles and reaches 230 after 29 ticks without overshoot; pwm_duty_b stays 0.
REQ-030 In RUN_A at 230, set req_duty_b=77 -> interlock_err pulses, duty A ramps to 0, then DEAD holds both duties at 0 for 10 cycles, and duty B ramps to 77 afterwards.
REQ-031 Both requests set in IDLE in the same cycle -> interlock_err=1 and RUN_A is entered; pwm_duty_b stays 0 throughout.
REQ-032 estop asserted mid-ramp (duty 120) -> both duties are 0 on the next edge, DEAD holds while estop is high, and IDLE is reached 10 cycles after release.
REQ-033 reset_n pulsed low mid-DEAD -> all outputs are 0 immediately; after release, req_duty_b=77 enters RUN_B without a dead-time wait.
REQ-034 PUMP_RAMP_EN undefined, req_duty_b=230 -> pwm_duty_b=230 one cycle after entering RUN_B; after the request drops to 0, the duty is 0 after one RAMP_DOWN cycle.
